dmem_responder: RTL and testbench

Multi-cycle data-memory responder: the target side of the CPU's load/store port. It accepts one word request at a time over a valid/ready handshake, inserts a programmable number of wait states, performs a byte-lane-masked write or a word read on its internal array, and returns a response over a valid/ready handshake. It replaces the zero-latency data memory when the core runs against a latency-bearing memory model.

---
 rtl/dmem_responder_pkg.sv | 19 +
 rtl/dmem_array.sv | 38 +++
 rtl/dmem_responder.sv | 128 ++++++++++++
 tb/tb_dmem_responder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: state encodings,
// byte-enable width, error code and the address legality check.
package dmem_responder_pkg;

    localparam int BE_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic ERR_ACCESS = 1'b1;

    // Misaligned, or word index beyond the array. The full 32-bit address is
    // compared so high address bits never alias into the array.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with a byte-masked synchronous write port and a synchronous
// read port. Contents are deliberately not reset.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic            rd_en,
    input  logic [AW-1:0]   addr,
    input  logic [31:0]     wdata,
    input  logic [BE_W-1:0] be,
    output logic [31:0]     rdata
);

    logic [31:0] mem [DEPTH];

    // Byte-lane write: lanes with a clear enable keep their old contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Full-word read, captured only when a load is performed.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one request at a time, waits a
// programmable number of cycles, performs the access on the edge entering
// RESP and holds the response until the requester takes it.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ready for a request (req_ready = 1)
// WAIT    | request latched, counting down wait states
// RESP    | response presented, held until rsp_ready
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int WAIT  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_wdata,
    input  logic [BE_W-1:0] req_be,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_rdata,
    output logic            rsp_err
);

    localparam int         AW        = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    logic [1:0]      state;
    logic [3:0]      cnt;
    logic            lat_we;
    logic [31:0]     lat_addr;
    logic [31:0]     lat_wdata;
    logic [BE_W-1:0] lat_be;
    logic            rsp_err_q;
    logic            rsp_load;

    logic            in_idle;
    logic            acc_fire;
    logic            acc_we;
    logic [31:0]     acc_addr;
    logic [31:0]     acc_wdata;
    logic [BE_W-1:0] acc_be;
    logic            acc_err;
    logic [31:0]     arr_rdata;

    // With zero wait states the access uses the request straight off the
    // port, since it happens on the acceptance edge itself.
    assign in_idle   = (state == ST_IDLE);
    assign acc_we    = in_idle ? req_we    : lat_we;
    assign acc_addr  = in_idle ? req_addr  : lat_addr;
    assign acc_wdata = in_idle ? req_wdata : lat_wdata;
    assign acc_be    = in_idle ? req_be    : lat_be;
    assign acc_err   = addr_err(acc_addr, DEPTH);
    assign acc_fire  = (in_idle && req_valid && (WAIT == 0)) ||
                       ((state == ST_WAIT) && (cnt == 4'd0));

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .wr_en (acc_fire && acc_we && !acc_err),
        .rd_en (acc_fire && !acc_we && !acc_err),
        .addr  (acc_addr[AW+1:2]),
        .wdata (acc_wdata),
        .be    (acc_be),
        .rdata (arr_rdata)
    );

    // FSM, wait-state down-counter, request latch and response flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            rsp_err_q <= 1'b0;
            rsp_load  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_be    <= req_be;
                        if (WAIT == 0) begin
                            state     <= ST_RESP;
                            rsp_err_q <= acc_err ? ERR_ACCESS : 1'b0;
                            rsp_load  <= !acc_we && !acc_err;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        state     <= ST_RESP;
                        rsp_err_q <= acc_err ? ERR_ACCESS : 1'b0;
                        rsp_load  <= !acc_we && !acc_err;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_err_q <= 1'b0;
                        rsp_load  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs are pure decodes of flops; stores and errors return zero data.
    assign req_ready = in_idle;
    assign rsp_valid = (state == ST_RESP);
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_load ? arr_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT=2 instance for most scenarios and
// a WAIT=0 instance for back-to-back throughput.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    int          errors = 0;
    int          checks = 0;

    // WAIT = 2 instance
    logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_be;

    // WAIT = 0 instance
    logic        z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
    logic [3:0]  z_req_be;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(1024), .WAIT(2)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH(1024), .WAIT(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    // One transaction on the WAIT=2 instance, starting and ending at a negedge.
    // lat counts cycles after the accept edge until rsp_valid (-1 on timeout).
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rdata,
                          output logic err, output int lat);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) lat = -1;
        rdata = rsp_rdata;
        err   = rsp_err;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, rd, er, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL store_latency got=%0d exp=3", lat); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL store_err got=%b exp=0", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL store_rdata got=%h exp=0", rd); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL store_ready_after got=%b exp=1", req_ready); end
        do_req(1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL load_latency got=%0d exp=3", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata got=%h exp=deadbeef", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL load_err got=%b exp=0", er); end
    endtask

    task automatic test_partial();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 32'h10, 32'h0000AA00, 4'b0010, rd, er, lat);
        do_req(1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat);
        checks++; if (rd !== 32'hDEADAAEF) begin errors++; $display("FAIL partial_be0010 got=%h exp=deadaaef", rd); end
        do_req(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL be0000_err got=%b exp=0", er); end
        do_req(1'b0, 32'h10, 32'h0, 4'b1111, rd, er, lat);
        checks++; if (rd !== 32'hDEADAAEF) begin errors++; $display("FAIL partial_be0000 got=%h exp=deadaaef", rd); end
        do_req(1'b1, 32'h10, 32'h11223344, 4'b1000, rd, er, lat);
        do_req(1'b0, 32'h10, 32'h0, 4'b0001, rd, er, lat);
        checks++; if (rd !== 32'h11ADAAEF) begin errors++; $display("FAIL partial_be1000 got=%h exp=11adaaef", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b0, 32'h13, 32'h0, 4'b1111, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL misalign_err got=%b exp=1", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL misalign_rdata got=%h exp=0", rd); end
        do_req(1'b1, 32'h0, 32'hCAFEF00D, 4'b1111, rd, er, lat);
        do_req(1'b1, 32'h1000, 32'h55555555, 4'b1111, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL range_err got=%b exp=1", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL range_rdata got=%h exp=0", rd); end
        do_req(1'b1, 32'h80000000, 32'h66666666, 4'b1111, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL highaddr_err got=%b exp=1", er); end
        do_req(1'b0, 32'h0, 32'h0, 4'b1111, rd, er, lat);
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL word0_intact got=%h exp=cafef00d", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL word0_err got=%b exp=0", er); end
    endtask

    task automatic test_backpressure();
        int k;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_wdata = 32'h0; req_be = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_arrives got=%b exp=1", rsp_valid); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_hold cyc=%0d got=%b exp=1", i, rsp_valid); end
            checks++; if (rsp_rdata !== 32'h11ADAAEF) begin errors++; $display("FAIL bp_rdata_hold cyc=%0d got=%h exp=11adaaef", i, rsp_rdata); end
            checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL bp_err_hold cyc=%0d got=%b exp=0", i, rsp_err); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low cyc=%0d got=%b exp=0", i, req_ready); end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_at_hs got=%b exp=0", req_ready); end
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_hs got=%b exp=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_after_hs got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_back_to_back();
        z_rsp_ready = 1'b1;
        z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 32'h4; z_req_wdata = 32'hA5A5A5A5; z_req_be = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        checks++; if (z_rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_rsp1_valid got=%b exp=1", z_rsp_valid); end
        checks++; if (z_req_ready !== 1'b0) begin errors++; $display("FAIL b2b_rsp1_ready got=%b exp=0", z_req_ready); end
        z_req_we = 1'b0; z_req_wdata = 32'h0;
        @(negedge clk);
        checks++; if (z_rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap_valid got=%b exp=0", z_rsp_valid); end
        checks++; if (z_req_ready !== 1'b1) begin errors++; $display("FAIL b2b_gap_ready got=%b exp=1", z_req_ready); end
        @(negedge clk);
        checks++; if (z_rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_rsp2_valid got=%b exp=1", z_rsp_valid); end
        checks++; if (z_rsp_rdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL b2b_rsp2_rdata got=%h exp=a5a5a5a5", z_rsp_rdata); end
        z_req_valid = 1'b0;
        @(negedge clk);
        checks++; if (z_rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got=%b exp=0", z_rsp_valid); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat; logic seen;
        do_req(1'b1, 32'h20, 32'h0, 4'b1111, rd, er, lat);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) rst = 1'b1;
            if (rsp_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_rsp got=%b exp=0", seen); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", req_ready); end
        do_req(1'b0, 32'h20, 32'h0, 4'b1111, rd, er, lat);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL midrst_word got=%h exp=0", rd); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL midrst_latency got=%0d exp=3", lat); end
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b1;
        z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_be = '0; z_rsp_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_store_load();
        test_partial();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
